// File: rtl/m_axi_read_poll_pkg.sv
// -----------------------------------------------------------------------------
// m_axi_read_poll_pkg
// Shared DFX sequencer definitions used by the DMA status poller:
//   - poll_state_e        : poller FSM state encoding
//   - MM2S/S2MM offsets   : DMA status register offsets from the DMA base
//   - STATUS_IDLE_BIT     : DMA status "Idle" bit index
//   - STATUS_ERR_MASK     : DMA status error bits [6:4]
//   - status_has_err()    : error-bit test on the low status bits
//   - resp_is_err()       : AXI response error test (anything but OKAY)
// -----------------------------------------------------------------------------
package m_axi_read_poll_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RADDR = 3'd1,
    ST_RDATA = 3'd2,
    ST_EVAL  = 3'd3,
    ST_WAIT  = 3'd4,
    ST_FIN   = 3'd5
  } poll_state_e;

  localparam logic [31:0] MM2S_STATUS_OFFSET = 32'h0000_0004;
  localparam logic [31:0] S2MM_STATUS_OFFSET = 32'h0000_0034;
  localparam int unsigned STATUS_IDLE_BIT    = 1;
  localparam logic [6:0]  STATUS_ERR_MASK    = 7'b111_0000;

  function automatic logic status_has_err(input logic [6:0] status_low);
    return |(status_low & STATUS_ERR_MASK);
  endfunction

  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp != 2'b00);
  endfunction

endpackage

// File: rtl/m_axi_read_poll_timer.sv
// -----------------------------------------------------------------------------
// poll_timer
// Loadable down-counter with a zero flag. Load wins over decrement, and the
// decrement saturates at zero so the zero flag stays asserted once reached.
// Ports:
//   clk, reset  : clock, asynchronous active-low reset (count -> 0)
//   load        : load load_value this cycle
//   load_value  : value to load
//   dec         : decrement by one (ignored at zero)
//   zero        : count is zero
// -----------------------------------------------------------------------------
module poll_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count_r;

  // Counter register: load, saturating decrement, otherwise hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= load_value;
    end else if (dec && (count_r != '0)) begin
      count_r <= count_r - WIDTH'(1);
    end
  end

  assign zero = (count_r == '0);

endmodule

// File: rtl/m_axi_read_poll.sv
// -----------------------------------------------------------------------------
// m_axi_read_poll
// AXI-Lite read master that polls the DMA MM2S and S2MM status registers in
// rounds until both report Idle, an error is seen, or the timeout expires.
// Ports:
//   clk, reset                      : clock, asynchronous active-low reset
//   M_AXI_AR* / M_AXI_R*            : AXI-Lite read address / read data channels
//   ext_bank0_out_dmaBaseAddr       : DMA register base, sampled at poll start
//   pollStart                       : level request; dropping it aborts/acks
//   pollInterval                    : idle cycles between rounds
//   pollTimeout                     : overall cycle limit, 0 disables
//   pollDone / pollErr / pollTimedOut : sticky result flags while in FIN
//   statusMm2s / statusS2mm         : last captured status values
// -----------------------------------------------------------------------------
module m_axi_read_poll
  import m_axi_read_poll_pkg::*;
#(
  parameter int GLOB_ADDR_WIDTH     = 32,
  parameter int GLOB_DATA_WIDTH     = 32,
  parameter int POLL_INTERVAL_WIDTH = 16,
  parameter int TIMEOUT_WIDTH       = 24
) (
  input  logic                           clk,
  input  logic                           reset,
  output logic [GLOB_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic                           M_AXI_ARVALID,
  input  logic                           M_AXI_ARREADY,
  input  logic [GLOB_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                     M_AXI_RRESP,
  input  logic                           M_AXI_RVALID,
  output logic                           M_AXI_RREADY,
  input  logic [GLOB_ADDR_WIDTH-1:0]     ext_bank0_out_dmaBaseAddr,
  input  logic                           pollStart,
  input  logic [POLL_INTERVAL_WIDTH-1:0] pollInterval,
  input  logic [TIMEOUT_WIDTH-1:0]       pollTimeout,
  output logic                           pollDone,
  output logic                           pollErr,
  output logic                           pollTimedOut,
  output logic [GLOB_DATA_WIDTH-1:0]     statusMm2s,
  output logic [GLOB_DATA_WIDTH-1:0]     statusS2mm
);

  poll_state_e                state_r, state_s;
  logic [GLOB_ADDR_WIDTH-1:0] base_r, base_s, araddr_r, araddr_s;
  logic [GLOB_DATA_WIDTH-1:0] mm2s_r, mm2s_s, s2mm_r, s2mm_s;
  logic arvalid_r, arvalid_s, rready_r, rready_s;
  logic sel_r, sel_s;          // 0: MM2S read of the round, 1: S2MM read
  logic err_r, err_s, to_en_r, to_en_s;
  logic done_r, done_s, perr_r, perr_s, tout_r, tout_s;
  logic start_s, ar_hs_s, rd_hs_s, rd_err_s, err_any_s, to_hit_s, both_idle_s;
  logic fin_err_s, fin_done_s, fin_to_s;
  logic int_zero_s, int_load_s, int_dec_s, to_zero_s, to_dec_s;

  assign ar_hs_s     = arvalid_r && M_AXI_ARREADY;
  assign rd_hs_s     = rready_r && M_AXI_RVALID;
  assign rd_err_s    = resp_is_err(M_AXI_RRESP) || status_has_err(M_AXI_RDATA[6:0]);
  assign err_any_s   = err_r || (rd_hs_s && rd_err_s);
  // The saturating timer keeps the hit asserted, so a limit reached mid-read
  // is still seen once the read completes.
  assign to_hit_s    = to_en_r && to_zero_s;
  assign both_idle_s = mm2s_r[STATUS_IDLE_BIT] && s2mm_r[STATUS_IDLE_BIT];
  assign start_s     = (state_r == ST_IDLE) && (state_s == ST_RADDR);
  assign int_load_s  = (state_s == ST_WAIT) && (state_r != ST_WAIT);
  assign int_dec_s   = (state_r == ST_WAIT);
  assign to_dec_s    = (state_r != ST_IDLE) && (state_r != ST_FIN);

  poll_timer #(.WIDTH(POLL_INTERVAL_WIDTH)) u_interval_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (int_load_s),
    .load_value (pollInterval),
    .dec        (int_dec_s),
    .zero       (int_zero_s)
  );

  poll_timer #(.WIDTH(TIMEOUT_WIDTH)) u_timeout_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (start_s),
    .load_value (pollTimeout),
    .dec        (to_dec_s),
    .zero       (to_zero_s)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic and the reason for entering FIN (error > done > timeout).
  always_comb begin
    state_s    = state_r;
    fin_err_s  = 1'b0;
    fin_done_s = 1'b0;
    fin_to_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pollStart && !done_r) state_s = ST_RADDR;
        else                      state_s = ST_IDLE;
      end
      ST_RADDR: begin
        if (ar_hs_s) state_s = ST_RDATA;
        else         state_s = ST_RADDR;
      end
      ST_RDATA: begin
        if (!rd_hs_s) begin
          state_s = ST_RDATA;
        end else if (!pollStart) begin
          state_s = ST_IDLE;          // aborted: read completed, no flags
        end else if (sel_r) begin
          state_s = ST_EVAL;
        end else if (to_hit_s) begin
          state_s   = ST_FIN;
          fin_err_s = err_any_s;
          fin_to_s  = !err_any_s;
        end else begin
          state_s = ST_RADDR;
        end
      end
      ST_EVAL: begin
        if (err_r) begin
          state_s   = ST_FIN;
          fin_err_s = 1'b1;
        end else if (both_idle_s) begin
          state_s    = ST_FIN;
          fin_done_s = 1'b1;
        end else if (to_hit_s) begin
          state_s  = ST_FIN;
          fin_to_s = 1'b1;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!pollStart) begin
          state_s = ST_IDLE;
        end else if (to_hit_s) begin
          state_s  = ST_FIN;
          fin_to_s = 1'b1;
        end else if (int_zero_s) begin
          state_s = ST_RADDR;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_FIN: begin
        if (!pollStart) state_s = ST_IDLE;
        else            state_s = ST_FIN;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath registers.
  always_comb begin
    arvalid_s = (state_s == ST_RADDR);
    rready_s  = (state_s == ST_RDATA);
    if (start_s) begin
      base_s  = ext_bank0_out_dmaBaseAddr;
      err_s   = 1'b0;
      to_en_s = (pollTimeout != '0);
    end else begin
      base_s  = base_r;
      err_s   = rd_hs_s ? (err_r || rd_err_s) : err_r;
      to_en_s = to_en_r;
    end
    // Address is computed once on entry to RADDR and then held stable.
    if ((state_s == ST_RADDR) && (state_r != ST_RADDR)) begin
      sel_s    = (state_r == ST_RDATA);
      araddr_s = base_s + (sel_s ? GLOB_ADDR_WIDTH'(S2MM_STATUS_OFFSET)
                                 : GLOB_ADDR_WIDTH'(MM2S_STATUS_OFFSET));
    end else begin
      sel_s    = sel_r;
      araddr_s = araddr_r;
    end
    if (rd_hs_s && !sel_r) mm2s_s = M_AXI_RDATA;
    else                   mm2s_s = mm2s_r;
    if (rd_hs_s && sel_r)  s2mm_s = M_AXI_RDATA;
    else                   s2mm_s = s2mm_r;
    if ((state_s == ST_FIN) && (state_r == ST_FIN)) begin
      done_s = done_r;
      perr_s = perr_r;
      tout_s = tout_r;
    end else if (state_s == ST_FIN) begin
      done_s = fin_done_s;
      perr_s = fin_err_s;
      tout_s = fin_to_s;
    end else begin
      done_s = 1'b0;
      perr_s = 1'b0;
      tout_s = 1'b0;
    end
  end

  // Output and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      arvalid_r <= 1'b0;
      rready_r  <= 1'b0;
      araddr_r  <= '0;
      base_r    <= '0;
      sel_r     <= 1'b0;
      err_r     <= 1'b0;
      to_en_r   <= 1'b0;
      mm2s_r    <= '0;
      s2mm_r    <= '0;
      done_r    <= 1'b0;
      perr_r    <= 1'b0;
      tout_r    <= 1'b0;
    end else begin
      arvalid_r <= arvalid_s;
      rready_r  <= rready_s;
      araddr_r  <= araddr_s;
      base_r    <= base_s;
      sel_r     <= sel_s;
      err_r     <= err_s;
      to_en_r   <= to_en_s;
      mm2s_r    <= mm2s_s;
      s2mm_r    <= s2mm_s;
      done_r    <= done_s;
      perr_r    <= perr_s;
      tout_r    <= tout_s;
    end
  end

  assign M_AXI_ARVALID = arvalid_r;
  assign M_AXI_ARADDR  = araddr_r;
  assign M_AXI_RREADY  = rready_r;
  assign pollDone      = done_r;
  assign pollErr       = perr_r;
  assign pollTimedOut  = tout_r;
  assign statusMm2s    = mm2s_r;
  assign statusS2mm    = s2mm_r;

endmodule

// File: tb/tb_m_axi_read_poll.sv
// -----------------------------------------------------------------------------
// tb_m_axi_read_poll
// Directed bench for m_axi_read_poll: an AXI-Lite slave with programmable
// ARREADY/RVALID delays answers status reads by address; a reference model
// tracks expected read addresses, captured status values and the single
// outstanding transaction and is compared against the DUT every cycle.
// -----------------------------------------------------------------------------
module tb_m_axi_read_poll;

  localparam logic [2:0] F_NONE = 3'b000;
  localparam logic [2:0] F_DONE = 3'b100;   // {pollDone, pollErr, pollTimedOut}
  localparam logic [2:0] F_ERR  = 3'b010;
  localparam logic [2:0] F_TO   = 3'b001;

  logic        clk;
  logic        reset;
  logic [31:0] M_AXI_ARADDR;
  logic        M_AXI_ARVALID;
  logic        M_AXI_ARREADY;
  logic [31:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RVALID;
  logic        M_AXI_RREADY;
  logic [31:0] ext_bank0_out_dmaBaseAddr;
  logic        pollStart;
  logic [15:0] pollInterval;
  logic [23:0] pollTimeout;
  logic        pollDone, pollErr, pollTimedOut;
  logic [31:0] statusMm2s, statusS2mm;

  m_axi_read_poll dut (
    .clk                       (clk),
    .reset                     (reset),
    .M_AXI_ARADDR              (M_AXI_ARADDR),
    .M_AXI_ARVALID             (M_AXI_ARVALID),
    .M_AXI_ARREADY             (M_AXI_ARREADY),
    .M_AXI_RDATA               (M_AXI_RDATA),
    .M_AXI_RRESP               (M_AXI_RRESP),
    .M_AXI_RVALID              (M_AXI_RVALID),
    .M_AXI_RREADY              (M_AXI_RREADY),
    .ext_bank0_out_dmaBaseAddr (ext_bank0_out_dmaBaseAddr),
    .pollStart                 (pollStart),
    .pollInterval              (pollInterval),
    .pollTimeout               (pollTimeout),
    .pollDone                  (pollDone),
    .pollErr                   (pollErr),
    .pollTimedOut              (pollTimedOut),
    .statusMm2s                (statusMm2s),
    .statusS2mm                (statusS2mm)
  );

  int cmp_cnt = 0;
  int fail_cnt = 0;

  // Slave configuration.
  int          ar_delay = 0;
  int          r_delay = 0;
  int          mm2s_busy_rounds = 0;
  int          mm2s_cnt = 0;
  logic [31:0] s2mm_val = 32'h2;
  logic [1:0]  s2mm_resp = 2'b00;

  // Reference model state.
  logic [31:0] m_base = 32'h0;
  logic [31:0] m_mm2s = 32'h0;
  logic [31:0] m_s2mm = 32'h0;
  logic [31:0] m_pend_val = 32'h0;
  logic [31:0] first_addr [2];
  logic [2:0]  exp_flags = F_NONE;
  bit          m_pend = 1'b0;
  bit          m_pend_s2mm = 1'b0;
  bit          m_last_s2mm = 1'b0;
  int          m_out = 0;
  int          m_nar = 0;
  int          m_nr = 0;
  int          idle_run = 0;
  int          min_gap = 1000000;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // AXI-Lite slave: ARREADY after ar_delay cycles, RVALID r_delay cycles after
  // the address handshake, data chosen by the register offset.
  initial begin : slave
    logic arv_p, arr_p, rv_p, rr_p;
    logic [31:0] addr_p, r_addr;
    int ar_cnt, r_cnt;
    bit r_pend;
    M_AXI_ARREADY = 1'b0;
    M_AXI_RVALID  = 1'b0;
    M_AXI_RDATA   = 32'h0;
    M_AXI_RRESP   = 2'b00;
    ar_cnt = 0; r_cnt = 0; r_pend = 1'b0; r_addr = 32'h0;
    forever begin
      @(negedge clk);
      arv_p = M_AXI_ARVALID; arr_p = M_AXI_ARREADY;
      rv_p = M_AXI_RVALID;   rr_p = M_AXI_RREADY;
      addr_p = M_AXI_ARADDR;
      @(posedge clk);
      #1;
      if (!reset) begin
        M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0;
        r_pend = 1'b0; ar_cnt = 0;
      end else begin
        if (rv_p && rr_p) M_AXI_RVALID = 1'b0;
        if (arv_p && arr_p) begin
          M_AXI_ARREADY = 1'b0;
          r_pend = 1'b1; r_cnt = r_delay; r_addr = addr_p; ar_cnt = 0;
        end else if (M_AXI_ARVALID && !M_AXI_ARREADY) begin
          if (ar_cnt >= ar_delay) M_AXI_ARREADY = 1'b1;
          else ar_cnt++;
        end else if (!M_AXI_ARVALID) begin
          ar_cnt = 0;
        end
        if (r_pend) begin
          if (r_cnt == 0) begin
            r_pend = 1'b0;
            M_AXI_RVALID = 1'b1;
            if (r_addr[7:0] == 8'h04) begin
              M_AXI_RDATA = (mm2s_cnt < mm2s_busy_rounds) ? 32'h0 : 32'h2;
              M_AXI_RRESP = 2'b00;
              mm2s_cnt++;
            end else begin
              M_AXI_RDATA = s2mm_val;
              M_AXI_RRESP = s2mm_resp;
            end
          end else begin
            r_cnt--;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the reference model.
  initial begin : compare
    logic [2:0]  f;
    logic [31:0] exp_addr;
    forever begin
      @(negedge clk);
      if (!reset) begin
        m_out = 0; m_pend = 1'b0; m_mm2s = 32'h0; m_s2mm = 32'h0;
        continue;
      end
      if (m_pend) begin
        if (m_pend_s2mm) m_s2mm = m_pend_val;
        else             m_mm2s = m_pend_val;
        m_pend = 1'b0;
      end
      chk("statusMm2s", 64'(statusMm2s), 64'(m_mm2s));
      chk("statusS2mm", 64'(statusS2mm), 64'(m_s2mm));
      chk("rready_iff_outstanding", 64'(M_AXI_RREADY), 64'(m_out == 1));
      if (M_AXI_ARVALID) chk("arvalid_while_outstanding", 64'(m_out), 64'd0);
      f = {pollDone, pollErr, pollTimedOut};
      if (f != F_NONE) chk("flag_value", 64'(f), 64'(exp_flags));
      if (!M_AXI_ARVALID && !M_AXI_RREADY) begin
        idle_run++;
      end else begin
        if (M_AXI_ARVALID && idle_run > 0 && m_nar > 0 && (m_nar % 2) == 0
            && idle_run < min_gap) min_gap = idle_run;
        idle_run = 0;
      end
      if (M_AXI_ARVALID && M_AXI_ARREADY) begin
        exp_addr = m_base + (((m_nar % 2) == 0) ? 32'h04 : 32'h34);
        chk("araddr", 64'(M_AXI_ARADDR), 64'(exp_addr));
        if (m_nar < 2) first_addr[m_nar] = M_AXI_ARADDR;
        m_last_s2mm = ((m_nar % 2) == 1);
        m_nar++;
        m_out = 1;
      end
      if (M_AXI_RVALID && M_AXI_RREADY) begin
        m_pend = 1'b1; m_pend_s2mm = m_last_s2mm; m_pend_val = M_AXI_RDATA;
        m_nr++;
        m_out = 0;
      end
    end
  end

  task automatic start_poll(input logic [31:0] base, input logic [15:0] intv,
                            input logic [23:0] tmo, input logic [2:0] expf);
    m_base = base; m_nar = 0; m_nr = 0; idle_run = 0; min_gap = 1000000;
    mm2s_cnt = 0; exp_flags = expf;
    first_addr[0] = 32'h0; first_addr[1] = 32'h0;
    ext_bank0_out_dmaBaseAddr = base;
    pollInterval = intv;
    pollTimeout = tmo;
    pollStart = 1'b1;
  endtask

  task automatic wait_flags(input int budget, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk); #1;
      cyc++;
    end while (!(pollDone || pollErr || pollTimedOut) && cyc < budget);
    chk("wait_bound", 64'(pollDone || pollErr || pollTimedOut), 64'd1);
  endtask

  task automatic end_poll();
    pollStart = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("flags_cleared", 64'({pollDone, pollErr, pollTimedOut}), 64'(F_NONE));
  endtask

  initial begin : stim
    int cyc;
    reset = 1'b0;
    pollStart = 1'b0;
    pollInterval = 16'd0;
    pollTimeout = 24'd0;
    ext_bank0_out_dmaBaseAddr = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_arvalid", 64'(M_AXI_ARVALID), 64'd0);
    chk("rst_rready", 64'(M_AXI_RREADY), 64'd0);
    chk("rst_flags", 64'({pollDone, pollErr, pollTimedOut}), 64'(F_NONE));
    chk("rst_status", 64'({statusMm2s, statusS2mm}), 64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;

    // Both idle on the first round.
    start_poll(32'h4040_0000, 16'd0, 24'd0, F_DONE);
    wait_flags(200, cyc);
    chk("t1_flags", 64'({pollDone, pollErr, pollTimedOut}), 64'(F_DONE));
    chk("t1_addr0", 64'(first_addr[0]), 64'h4040_0004);
    chk("t1_addr1", 64'(first_addr[1]), 64'h4040_0034);
    chk("t1_reads", 64'(m_nar), 64'd2);
    chk("t1_mm2s", 64'(statusMm2s), 64'h2);
    end_poll();

    // Address offsets wrap modulo 2^32.
    start_poll(32'hFFFF_FFE0, 16'd0, 24'd0, F_DONE);
    wait_flags(200, cyc);
    chk("wrap_addr0", 64'(first_addr[0]), 64'hFFFF_FFE4);
    chk("wrap_addr1", 64'(first_addr[1]), 64'h0000_0014);
    end_poll();

    // MM2S busy for three rounds, 10-cycle interval.
    mm2s_busy_rounds = 3;
    start_poll(32'h4040_0000, 16'd10, 24'd0, F_DONE);
    wait_flags(2000, cyc);
    chk("t2_flags", 64'({pollDone, pollErr, pollTimedOut}), 64'(F_DONE));
    chk("t2_reads", 64'(m_nar), 64'd8);
    chk("t2_min_gap_ge_10", 64'(min_gap >= 10), 64'd1);
    end_poll();

    // SLVERR on the S2MM read.
    mm2s_busy_rounds = 0; s2mm_resp = 2'b10;
    start_poll(32'h4040_0000, 16'd0, 24'd0, F_ERR);
    wait_flags(200, cyc);
    chk("t3a_flags", 64'({pollDone, pollErr, pollTimedOut}), 64'(F_ERR));
    end_poll();

    // Error bit 4 in the status value (Idle bit also set: error wins).
    s2mm_resp = 2'b00; s2mm_val = 32'h0000_0012;
    start_poll(32'h4040_0000, 16'd0, 24'd0, F_ERR);
    wait_flags(200, cyc);
    chk("t3b_flags", 64'({pollDone, pollErr, pollTimedOut}), 64'(F_ERR));
    chk("t3b_s2mm", 64'(statusS2mm), 64'h12);
    end_poll();

    // Never idle, timeout 50, slow ARREADY.
    s2mm_val = 32'h2; mm2s_busy_rounds = 1000; ar_delay = 5;
    start_poll(32'h4040_0000, 16'd3, 24'd50, F_TO);
    wait_flags(500, cyc);
    chk("t4_flags", 64'({pollDone, pollErr, pollTimedOut}), 64'(F_TO));
    chk("t4_not_early", 64'(cyc >= 50), 64'd1);
    chk("t4_no_outstanding", 64'(m_out), 64'd0);
    chk("t4_bus_quiet", 64'({M_AXI_ARVALID, M_AXI_RREADY}), 64'd0);
    end_poll();

    // Abort during RDATA with a slow RVALID.
    ar_delay = 0; r_delay = 8;
    start_poll(32'h4040_0000, 16'd0, 24'd0, F_NONE);
    cyc = 0;
    while (!M_AXI_RREADY && cyc < 20) begin @(negedge clk); #1; cyc++; end
    chk("t5_reached_rdata", 64'(M_AXI_RREADY), 64'd1);
    pollStart = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    chk("t5_one_read", 64'(m_nar), 64'd1);
    chk("t5_handshake_done", 64'(m_nr), 64'd1);
    chk("t5_bus_quiet", 64'({M_AXI_ARVALID, M_AXI_RREADY}), 64'd0);
    chk("t5_flags", 64'({pollDone, pollErr, pollTimedOut}), 64'(F_NONE));

    // Asynchronous reset while ARVALID is held.
    r_delay = 0; ar_delay = 20;
    start_poll(32'h4040_0000, 16'd0, 24'd0, F_NONE);
    cyc = 0;
    while (!M_AXI_ARVALID && cyc < 20) begin @(negedge clk); #1; cyc++; end
    chk("t6_in_raddr", 64'(M_AXI_ARVALID), 64'd1);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_arvalid_async", 64'(M_AXI_ARVALID), 64'd0);
    pollStart = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("t6_arvalid", 64'(M_AXI_ARVALID), 64'd0);
    chk("t6_rready", 64'(M_AXI_RREADY), 64'd0);
    chk("t6_araddr", 64'(M_AXI_ARADDR), 64'd0);
    chk("t6_flags", 64'({pollDone, pollErr, pollTimedOut}), 64'(F_NONE));
    chk("t6_status", 64'({statusMm2s, statusS2mm}), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
